// File: rtl/of_interlock_if.sv
// OF-stage interlock bundle: OF instruction and branch
// redirect in, stall/flush decisions and counters out.
interface of_interlock_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      OF_IR;
  logic             isBranchTaken;
  logic             isDataInterLock;
  logic             isBranchInterLock;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output OF_IR,
    output isBranchTaken,
    input  isDataInterLock,
    input  isBranchInterLock,
    input  stallCount,
    input  flushCount
  );

  modport slave (
    input  OF_IR,
    input  isBranchTaken,
    output isDataInterLock,
    output isBranchInterLock,
    output stallCount,
    output flushCount
  );
endinterface

// File: rtl/of_interlock_unit.sv
// OF hazard unit: 3-slot dest scoreboard (EX/MA/RW).
// OF_INTERLOCK_FORWARDING_EN: only load-use in EX stalls.
module of_interlock_unit #(
  parameter logic [31:0] NOP_IR = 32'h68000000,
  parameter int          CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  of_interlock_if.slave bus
);
  typedef struct packed {
    logic       v;
    logic [3:0] rd;
    logic       ld;
  } slot_t;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  logic [4:0] opc;
  logic       imm;
  logic [3:0] rd, rs1, rs2;
  logic       live;
  logic       unused_low;

  assign opc        = bus.OF_IR[31:27];
  assign imm        = bus.OF_IR[26];
  assign rd         = bus.OF_IR[25:22];
  assign rs1        = bus.OF_IR[21:18];
  assign rs2        = bus.OF_IR[17:14];
  assign live       = (bus.OF_IR != NOP_IR);
  assign unused_low = ^bus.OF_IR[13:0];

  logic is_alu, is_cmp, is_mvn;
  logic is_ld, is_st, is_call, is_ret;

  assign is_alu  = live && (opc inside {OP_ADD, OP_SUB,
                   OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR,
                   OP_LSL, OP_LSR, OP_ASR});
  assign is_cmp  = live && (opc == OP_CMP);
  assign is_mvn  = live && (opc inside {OP_MOV, OP_NOT});
  assign is_ld   = live && (opc == OP_LD);
  assign is_st   = live && (opc == OP_ST);
  assign is_call = live && (opc == OP_CALL);
  assign is_ret  = live && (opc == OP_RET);

  logic [2:0]       s_v;
  logic [2:0][3:0]  s_r;
  slot_t            d_new;

  // Decode OF sources and destination per opcode class.
  always_comb begin
    s_v   = '0;
    s_r   = '0;
    d_new = '0;
    unique case (1'b1)
      is_alu: begin
        s_v[0] = 1'b1;   s_r[0] = rs1;
        s_v[1] = !imm;   s_r[1] = rs2;
        d_new  = '{v: 1'b1, rd: rd, ld: 1'b0};
      end
      is_cmp: begin
        s_v[0] = 1'b1;   s_r[0] = rs1;
        s_v[1] = !imm;   s_r[1] = rs2;
      end
      is_mvn: begin
        s_v[1] = !imm;   s_r[1] = rs2;
        d_new  = '{v: 1'b1, rd: rd, ld: 1'b0};
      end
      is_ld: begin
        s_v[0] = 1'b1;   s_r[0] = rs1;
        d_new  = '{v: 1'b1, rd: rd, ld: 1'b1};
      end
      is_st: begin
        s_v[0] = 1'b1;   s_r[0] = rs1;
        s_v[2] = 1'b1;   s_r[2] = rd;
      end
      is_call: d_new = '{v: 1'b1, rd: 4'd15, ld: 1'b0};
      is_ret: begin
        s_v[0] = 1'b1;   s_r[0] = 4'd15;
      end
      default: ;
    endcase
  end

  slot_t [2:0] sb;
  logic  [2:0] hit;
  logic        hazard;

  // Match every live source against each valid slot.
  always_comb begin
    hit = '0;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 3; s++) begin
        if (sb[k].v && s_v[s] && sb[k].rd == s_r[s])
          hit[k] = 1'b1;
      end
    end
  end

`ifdef OF_INTERLOCK_FORWARDING_EN
  assign hazard = hit[0] && sb[0].ld;
`else
  assign hazard = |hit;
`endif

  logic di, bi;

  assign bi = rst_n && bus.isBranchTaken;
  assign di = rst_n && hazard && !bus.isBranchTaken;

  assign bus.isDataInterLock   = di;
  assign bus.isBranchInterLock = bi;

  // Shift scoreboard; a stalled or flushed OF enters EX as a bubble.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
    end else begin
      sb[2] <= sb[1];
      sb[1] <= sb[0];
      sb[0] <= (di || bi) ? slot_t'('0) : d_new;
    end
  end

  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating stall and flush cycle counters.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (di && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (bi && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.stallCount = stall_q;
  assign bus.flushCount = flush_q;
endmodule

// File: tb/tb_of_interlock_unit.sv
// Bench for of_interlock_unit: directed vector table,
// corner sequences, and random run against a mask model.
module tb_of_interlock_unit;
  localparam int W   = 4;
  localparam int SAT = 15;
  localparam logic [31:0] NOP = 32'h68000000;
`ifdef OF_INTERLOCK_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  of_interlock_if #(.CNT_W(W)) bus ();

  of_interlock_unit #(.NOP_IR(NOP), .CNT_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  int h_rd [3];
  bit h_ld [3];
  int m_sc, m_fc;

  typedef struct {
    logic [31:0] ir;
    logic        bt;
    logic        di;
    logic        bi;
  } vec_t;

  vec_t tbl [19];

  function automatic logic [31:0] enc(int op, bit i, int rd,
                                      int rs1, int rs2);
    return {op[4:0], i, rd[3:0], rs1[3:0], rs2[3:0], 14'd0};
  endfunction

  function automatic int rmask(logic [31:0] ir);
    int op  = int'(ir[31:27]);
    bit i   = ir[26];
    int rd  = int'(ir[25:22]);
    int rs1 = int'(ir[21:18]);
    int rs2 = int'(ir[17:14]);
    if (ir == NOP) return 0;
    case (op)
      0, 1, 2, 3, 4, 5, 6, 7, 10, 11, 12:
        return (1 << rs1) | (i ? 0 : (1 << rs2));
      14: return 1 << rs1;
      15: return (1 << rs1) | (1 << rd);
      8, 9: return i ? 0 : (1 << rs2);
      20: return 1 << 15;
      default: return 0;
    endcase
  endfunction

  function automatic int wreg(logic [31:0] ir);
    int op = int'(ir[31:27]);
    if (ir == NOP) return -1;
    case (op)
      0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 14:
        return int'(ir[25:22]);
      19: return 15;
      default: return -1;
    endcase
  endfunction

  function automatic bit m_di(logic [31:0] ir, bit bt);
    int m = rmask(ir);
    bit hz = 1'b0;
    if (FWD) begin
      hz = h_rd[0] >= 0 && h_ld[0] && ((m >> h_rd[0]) & 1) == 1;
    end else begin
      for (int k = 0; k < 3; k++)
        if (h_rd[k] >= 0 && ((m >> h_rd[k]) & 1) == 1) hz = 1'b1;
    end
    return hz && !bt;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      h_rd[k] = -1;
      h_ld[k] = 1'b0;
    end
    m_sc = 0;
    m_fc = 0;
  endtask

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic [31:0] ir, bit bt);
    bus.OF_IR = ir;
    bus.isBranchTaken = bt;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic advance();
    bit di = m_di(bus.OF_IR, bus.isBranchTaken);
    bit bt = bus.isBranchTaken;
    bit kill = di || bt;
    h_rd[2] = h_rd[1]; h_ld[2] = h_ld[1];
    h_rd[1] = h_rd[0]; h_ld[1] = h_ld[0];
    h_rd[0] = kill ? -1 : wreg(bus.OF_IR);
    h_ld[0] = !kill && bus.OF_IR != NOP &&
              bus.OF_IR[31:27] == 5'd14;
    if (di && m_sc < SAT) m_sc++;
    if (bt && m_fc < SAT) m_fc++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] add_r1, sub_r4, ld_r5, add_r6;
    add_r1 = enc(0, 0, 1, 2, 3);
    sub_r4 = enc(1, 0, 4, 1, 2);
    ld_r5  = enc(14, 1, 5, 2, 0);
    add_r6 = enc(0, 0, 6, 5, 5);

    tbl[0]  = '{add_r1, 0, 0, 0};
    tbl[1]  = '{sub_r4, 0, !FWD, 0};
    tbl[2]  = '{sub_r4, 0, !FWD, 0};
    tbl[3]  = '{sub_r4, 0, !FWD, 0};
    tbl[4]  = '{sub_r4, 0, 0, 0};
    tbl[5]  = '{NOP, 0, 0, 0};
    tbl[6]  = '{enc(9, 1, 3, 0, 0), 0, 0, 0};
    tbl[7]  = '{enc(0, 1, 1, 2, 3), 0, 0, 0};
    tbl[8]  = '{NOP, 0, 0, 0};
    tbl[9]  = '{NOP, 0, 0, 0};
    tbl[10] = '{NOP, 0, 0, 0};
    tbl[11] = '{ld_r5, 0, 0, 0};
    tbl[12] = '{add_r6, 0, 1, 0};
    tbl[13] = '{add_r6, 0, !FWD, 0};
    tbl[14] = '{add_r6, 0, !FWD, 0};
    tbl[15] = '{add_r6, 0, 0, 0};
    tbl[16] = '{enc(0, 0, 7, 1, 1), 0, 0, 0};
    tbl[17] = '{enc(1, 0, 8, 7, 7), 1, 0, 1};
    tbl[18] = '{enc(9, 0, 9, 0, 8), 0, 0, 0};

    model_reset();
    drive(add_r1, 1'b1);
    #7;
    chk("rst_di", int'(bus.isDataInterLock), 0);
    chk("rst_bi", int'(bus.isBranchInterLock), 0);
    chk("rst_sc", int'(bus.stallCount), 0);
    chk("rst_fc", int'(bus.flushCount), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    for (int r = 0; r < 19; r++) begin
      drive(tbl[r].ir, tbl[r].bt);
      settle();
      chk($sformatf("vec%0d_di", r),
          int'(bus.isDataInterLock), int'(tbl[r].di));
      chk($sformatf("vec%0d_bi", r),
          int'(bus.isBranchInterLock), int'(tbl[r].bi));
      advance();
    end
    chk("tbl_sc", int'(bus.stallCount), FWD ? 1 : 6);
    chk("tbl_fc", int'(bus.flushCount), 1);

    drive(add_r1, 1'b0);
    settle();
    advance();
    drive(sub_r4, 1'b0);
    settle();
    chk("mid_stall1", int'(bus.isDataInterLock), int'(!FWD));
    advance();
    settle();
    chk("mid_stall2", int'(bus.isDataInterLock), int'(!FWD));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_di", int'(bus.isDataInterLock), 0);
    chk("mid_rst_sc", int'(bus.stallCount), 0);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("mid_rel_di", int'(bus.isDataInterLock), 0);
    advance();
    chk("mid_rel_sc", int'(bus.stallCount), 0);

    for (int c = 0; c < 20; c++) begin
      drive(NOP, 1'b1);
      settle();
      advance();
    end
    chk("sat_fc", int'(bus.flushCount), SAT);

    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      int op = $urandom_range(0, 23);
      logic [31:0] ir;
      bit bt;
      ir = enc(op, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3));
      if (op == 23) ir = NOP;
      else if (op > 20) ir[31:27] = 5'($urandom_range(21, 31));
      bt = ($urandom_range(0, 7) == 0);
      drive(ir, bt);
      settle();
      chk("rnd_di", int'(bus.isDataInterLock), int'(m_di(ir, bt)));
      chk("rnd_bi", int'(bus.isBranchInterLock), int'(bt));
      advance();
      chk("rnd_sc", int'(bus.stallCount), m_sc);
      chk("rnd_fc", int'(bus.flushCount), m_fc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/of_interlock_unit.md
# of_interlock_unit

Hazard-detection unit that generates `isDataInterLock` and `isBranchInterLock` for the OF→EX pipeline latch and the IF/OF stall logic. It decodes the instruction currently in OF against a three-entry scoreboard of in-flight destination registers (EX, MA, RW). It also converts a taken-branch indication from EX into a flush request. Both interlock outputs are consumed on the same `negedge clk` at which the pipeline latches capture.

## Interface

**Parameters**
- `NOP_IR`, default 32'h68000000: encoding treated as a bubble; it has no sources and no destination.
- `CNT_W`, default 16: width of the performance counters.

**Ports**
- `clk`, input, 1: pipeline clock. All state updates on negedge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `OF_IR`, input, 32: instruction held in OF.
- `isBranchTaken`, input, 1: EX branch unit reports that the instruction in EX redirects the PC.
- `isDataInterLock`, output, 1: combinational; hold IF/OF and insert a bubble into EX.
- `isBranchInterLock`, output, 1: combinational; flush OF→EX and IF→OF.
- `stallCount`, output, CNT_W: saturating count of data-stall cycles.
- `flushCount`, output, CNT_W: saturating count of branch-flush cycles.

## Operation

**Decode.** Fields: opcode `[31:27]`, I `[26]`, rd `[25:22]`, rs1 `[21:18]`, rs2 `[17:14]`.

**Sources.**
- rs1 is a source for add, sub, mul, div, mod, cmp, and, or, lsl, lsr, asr, ld, st.
- rs2 is a source for the same set excluding ld and st, only when I=0.
- st additionally reads rd.
- ret reads r15.
- mov, not: rs2 only when I=0.
- nop, b, beq, bgt, call read no registers.

**Destination.**
- rd for add, sub, mul, div, mod, and, or, not, mov, lsl, lsr, asr, ld.
- r15 for call.
- None for cmp, st, nop, branches, ret.

**Scoreboard.** Each slot holds {valid, dest[3:0], isLoad}. On every `negedge clk`:
- RW ← MA, MA ← EX.
- EX ← decoded OF destination, or invalid when either interlock is asserted.

**Data hazard.** An OF source matches a valid slot's destination.
- Without the forwarding feature: any match in EX, MA, or RW.
- With the forwarding feature: only a match against an EX slot with isLoad=1 (load-use).

**Output logic.**
- `isBranchInterLock` = `isBranchTaken`.
- `isDataInterLock` = hazard AND NOT `isBranchTaken`. Branch has priority, because the OF instruction is discarded anyway.
- Both outputs are forced to 0 while `rst_n` = 0.

**Counters.**
- `stallCount` increments on each negedge where `isDataInterLock` = 1.
- `flushCount` increments on each negedge where `isBranchInterLock` = 1.
- Both saturate at all-ones.

## Timing

- Outputs are combinational from `OF_IR`, `isBranchTaken`, and the scoreboard. There is no added latency, so they are valid before the negedge that consumes them.
- Scoreboard and counters update on negedge only.
- Reset values: all slots invalid; `stallCount` = 0; `flushCount` = 0; both interlocks 0.
- A reset asserted mid-stall clears the scoreboard immediately. The first negedge after release sees an empty scoreboard, so no residual stall occurs.
- Without forwarding, a dependent instruction directly behind its producer stalls exactly 3 cycles. It proceeds on the negedge after the producer leaves RW.
- With forwarding, load-use stalls exactly 1 cycle; all other dependences stall 0 cycles.
- A stalled OF instruction is re-evaluated every cycle; the stall deasserts combinationally once the matching slot clears.
- A match against r0 is still a hazard. The register file has no hardwired zero.

## Configuration

- `OF_INTERLOCK_FORWARDING_EN` defined: the EX/MA/RW→OF/EX forwarding paths exist, and only load-use in the EX slot stalls.
- Not defined: every RAW dependence on EX, MA, or RW stalls.
- The scoreboard structure is identical in both builds; only the hazard predicate differs.

## Test plan

- **Reset.** Hold `rst_n` = 0 with `OF_IR` = 32'h0048C000 (add r1,r2,r3) and `isBranchTaken` = 1 → both interlocks 0, both counters 0.
- **RAW, no forwarding.** add r1,r2,r3 followed by sub r4,r1,r2 → `isDataInterLock` high for 3 negedges, then `stallCount` = 3. Same sequence with `OF_INTERLOCK_FORWARDING_EN` defined → 0 stalls.
- **Load-use with forwarding.** ld r5,[r2] followed by add r6,r5,r5 → exactly 1 stall cycle and `stallCount` = 1. Inserting a nop between them → 0 stalls.
- **Immediate form.** A writer of r3, then add r1,r2,#imm whose rs2 field equals 3 with I=1 → no stall.
- **Branch priority.** With a pending RAW hazard, pulse `isBranchTaken` for 1 cycle → `isBranchInterLock` = 1, `isDataInterLock` = 0, `flushCount` +1, and the EX slot is invalid at the next negedge.
- **Reset mid-stall.** During the second stall cycle, pulse `rst_n` low → scoreboard cleared. After release, the same OF instruction proceeds with no stall and `stallCount` = 0.
